// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter that owns the select of a shared 32-bit 4:1 mux in
//   front of a single downstream consumer. A winning requester keeps the mux
//   for as long as it asserts lock, up to MAX_BEATS accepted beats. After
//   that it is forced to give the mux up so the others get a turn.
//
// Parameters
//   MAX_BEATS : accepted beats per grant before a forced release (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   requester i presents a valid beat on mux input i
//   lock[3:0]  in   requester i wants to keep ownership after this beat
//   out_ready  in   consumer accepts the beat this cycle
//   choice[1:0] out mux select (encoded owner index), registered
//   gnt[3:0]   out  one-hot owner indication, registered
//   out_valid  out  beat on the mux output is valid
//   ack[3:0]   out  one-hot pulse: beat of requester i accepted this cycle
//   busy       out  arbiter is in the OWN state
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       out_ready,
  output logic [1:0] choice,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Index of the final beat a grant may carry before it must let go.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  state_t     state_q,    state_d;
  logic [1:0] choice_q,   choice_d;
  logic [3:0] gnt_q,      gnt_d;
  logic [1:0] ptr_q,      ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  // -------------------------------------------------------------------------
  // Round-robin search: rotate req so that bit 0 is the ptr position. The
  // first set bit of the rotated vector is then the winner's offset from ptr.
  // -------------------------------------------------------------------------
  logic [3:0] req_rot;
  logic [1:0] win_ofs;
  logic [1:0] win_idx;
  logic       any_req;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[2'(ptr_q + 2'(gi))];
    end
  endgenerate

  always_comb begin
    win_ofs = 2'd0;
    // Scan from the top down so that the lowest set offset wins.
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_ofs = 2'(k);
      end
    end
  end

  assign any_req = |req;
  assign win_idx = ptr_q + win_ofs;

  // -------------------------------------------------------------------------
  // Owner-side handshake. In OWN, choice_q holds the owner index, so only
  // the owner's req/lock bits matter; the bits of the others are ignored.
  // -------------------------------------------------------------------------
  logic owner_req;
  logic owner_lock;
  logic accept;
  logic last_beat;
  logic release_own;

  assign owner_req  = req[choice_q];
  assign owner_lock = lock[choice_q];
  assign out_valid  = (state_q == OWN) && owner_req;
  assign accept     = out_valid && out_ready;
  assign last_beat  = (beat_cnt_q == LAST_BEAT);

  // Release on withdrawal, on an unlocked beat, or on the final permitted
  // beat. A withdrawal never produces an ack because out_valid is already low.
  assign release_own = !owner_req || (accept && (!owner_lock || last_beat));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
      assign ack[gi] = accept && (choice_q == 2'(gi));
    end
  endgenerate

  assign busy   = (state_q == OWN);
  assign gnt    = gnt_q;
  assign choice = choice_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    choice_d   = choice_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      IDLE: begin
        // choice is not touched here, so the mux select stays quiet while
        // nobody is granted.
        gnt_d = 4'b0000;
        if (any_req) begin
          state_d    = OWN;
          choice_d   = win_idx;
          gnt_d      = 4'b0001 << win_idx;
          beat_cnt_d = 8'd0;
        end
      end

      OWN: begin
        if (release_own) begin
          // The releasing beat is not counted; the next search starts just
          // past the old owner so it drops to lowest priority.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = choice_q + 2'd1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      choice_q   <= 2'd0;
      gnt_q      <= 4'b0000;
      ptr_q      <= 2'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      choice_q   <= choice_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
